// File: rtl/aes_out_serializer.sv
// aes_out_serializer: buffers 128-bit cipher blocks from the AES encrypt
// block in a small block FIFO and streams each block out as WORD_W-bit
// words, most-significant word first, with a last-word marker.
//
// Output handshake: a word transfers on every rising edge where
// out_valid && out_ready. out_valid, out_word and out_last depend only on
// registered state. They hold stable while out_ready is low, and out_valid
// never drops without a transfer except on reset.
module aes_out_serializer #(
    parameter int DATA_W = 128,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] cipher_text,
    output logic [WORD_W-1:0] out_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              full,
    output logic              overflow,
    input  logic              overflow_clr
);

    localparam int N     = DATA_W / WORD_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              overflow_q, overflow_d;

    logic              xfer;
    logic              pop;
    logic              push;
    logic              drop;
    logic [DATA_W-1:0] head;

    // Handshake decode: a pop is the transfer of the head block's last word,
    // and it frees a slot early enough to accept a push in the same cycle.
    always_comb begin
        xfer = out_valid && out_ready;
        pop  = xfer && (idx_q == IDX_W'(N - 1));
        push = valid_in && ((count_q != CNT_W'(DEPTH)) || pop);
        drop = valid_in && !push;
    end

    // Select the current word of the head entry, MSW at idx 0.
    always_comb begin
        head     = mem_q[rd_ptr_q];
        out_word = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                out_word = head[DATA_W-1-i*WORD_W -: WORD_W];
            end
        end
        out_valid = (count_q != '0);
        out_last  = out_valid && (idx_q == IDX_W'(N - 1));
        full      = (count_q == CNT_W'(DEPTH));
        overflow  = overflow_q;
    end

    // Next-state logic for storage, pointers, occupancy, word index and flag.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;

        if (push) begin
            mem_d[wr_ptr_q] = cipher_text;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end

        if (xfer) begin
            if (pop) begin
                idx_d    = '0;
                rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    // State registers; reset discards all buffered data including partial blocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
